// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder and its byte-lane RAM.
package data_mem_responder_pkg;

  typedef logic [31:0] uint32;

  localparam int MEM_WAIT_W = 4;
  localparam int MEM_LANES  = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_resp_state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the core memory controller (master) and the responder (slave).
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic       req_valid;
  logic       req_ready;
  uint32      address;
  logic       read;
  logic       write;
  logic [3:0] maskByte;
  uint32      dataMemIn;
  uint32      dataMemOut;
  logic       resp_valid;
  logic       err;

  modport master (
    output req_valid, address, read, write, maskByte, dataMemIn,
    input  req_ready, dataMemOut, resp_valid, err
  );

  modport slave (
    input  req_valid, address, read, write, maskByte, dataMemIn,
    output req_ready, dataMemOut, resp_valid, err
  );

endinterface

// File: rtl/data_mem_responder_ram.sv
// DEPTH_WORDS x 32 RAM built from independent byte lanes: synchronous read, per-lane write enable, no reset.
module dmem_bytelane_ram
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic                           re,
  input  logic [MEM_LANES-1:0]           we,
  input  uint32                          wdata,
  output uint32                          rdata
);

  for (genvar l = 0; l < MEM_LANES; l++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rd_byte;

    always_ff @(posedge clk) begin
      if (we[l]) mem[addr] <= wdata[8*l +: 8];
      if (re)    rd_byte   <= mem[addr];
    end

    assign rdata[8*l +: 8] = rd_byte;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: latches one request, waits WAIT_STATES cycles, accesses the RAM, pulses a response.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  mem_resp_state_t        state;
  logic [MEM_WAIT_W-1:0]  cnt;
  logic [29:0]            idx_q;
  logic                   rd_q, wr_q;
  logic [MEM_LANES-1:0]   mask_q;
  uint32                  wdata_q;
  logic                   err_q;
  logic                   rd_out_q;
  uint32                  dout_q;

  logic                   accept, bad, access;
  logic                   ram_re;
  logic [MEM_LANES-1:0]   ram_we;
  uint32                  ram_rdata;

  assign accept = (state == IDLE) && bus.req_valid && (bus.read || bus.write);
  assign bad    = ({2'b00, idx_q} >= 32'(DEPTH_WORDS)) || (rd_q && wr_q);
  assign access = (state == BUSY) && (cnt == '0);
  assign ram_re = access && rd_q && !bad;
  assign ram_we = (access && wr_q && !bad) ? mask_q : '0;

  dmem_bytelane_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .addr  (idx_q[AW-1:0]),
    .re    (ram_re),
    .we    (ram_we),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      mask_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rd_out_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          idx_q   <= bus.address[31:2];
          rd_q    <= bus.read;
          wr_q    <= bus.write;
          mask_q  <= bus.maskByte;
          wdata_q <= bus.dataMemIn;
          cnt     <= MEM_WAIT_W'(WAIT_STATES);
          state   <= BUSY;
        end
        BUSY: if (cnt != '0) begin
          cnt <= cnt - MEM_WAIT_W'(1);
        end else begin
          err_q    <= bad;
          rd_out_q <= rd_q && !bad;
          if (bad) dout_q <= '0;
          state    <= RESP;
        end
        RESP: begin
          // The RAM read data is live during RESP; capture it so it holds afterwards.
          if (rd_out_q) dout_q <= ram_rdata;
          rd_out_q <= 1'b0;
          err_q    <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.err        = err_q;
  assign bus.dataMemOut = rd_out_q ? ram_rdata : dout_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with one wait state, one with none, sharing a driver.
module tb_data_mem_responder;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if b0 ();
  data_mem_responder_if b1 ();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  logic        sel = 1'b1;
  logic        rv = 1'b0, rd_d = 1'b0, wr_d = 1'b0;
  logic [31:0] addr_d = '0, data_d = '0;
  logic [3:0]  mask_d = '0;

  assign b0.req_valid = rv & ~sel;
  assign b1.req_valid = rv & sel;
  assign b0.address = addr_d;  assign b1.address = addr_d;
  assign b0.read = rd_d;       assign b1.read = rd_d;
  assign b0.write = wr_d;      assign b1.write = wr_d;
  assign b0.maskByte = mask_d; assign b1.maskByte = mask_d;
  assign b0.dataMemIn = data_d; assign b1.dataMemIn = data_d;

  logic        rdy, rsp, er;
  logic [31:0] dout;
  assign rdy  = sel ? b1.req_ready  : b0.req_ready;
  assign rsp  = sel ? b1.resp_valid : b0.resp_valid;
  assign er   = sel ? b1.err        : b0.err;
  assign dout = sel ? b1.dataMemOut : b0.dataMemOut;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // One request on the selected DUT; checks latency, ready window, err and read word.
  task automatic do_req(input logic s, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [3:0] m, input logic [31:0] d, input logic exp_err,
                        input logic [31:0] exp_dout, input string nm);
    int w, n, resp_at;
    logic ready_ok;
    w = s ? 1 : 0;
    @(negedge clk);
    sel = s; rd_d = rd; wr_d = wr; addr_d = a; mask_d = m; data_d = d; rv = 1'b1;
    #1;
    n = 0;
    while (!rdy && n < 50) begin @(negedge clk); n++; end
    if (!rdy) begin
      chk({nm, "_accept_timeout"}, 32'(rdy), 32'd1);
      rv = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    rv = 1'b0; rd_d = 1'($urandom); wr_d = 1'($urandom);
    addr_d = $urandom; mask_d = 4'($urandom); data_d = $urandom;
    resp_at = -1; ready_ok = 1'b1;
    for (int k = 1; k <= w + 3; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= w + 2 && rdy) ready_ok = 1'b0;
      if (k == w + 3 && !rdy) ready_ok = 1'b0;
      if (rsp) resp_at = (resp_at < 0) ? k : 99;
      if (k == w + 2) begin
        chk({nm, "_err"}, 32'(er), 32'(exp_err));
        chk({nm, "_dout"}, dout, exp_dout);
      end
    end
    chk({nm, "_resp_cycle"}, 32'(resp_at), 32'(w + 2));
    chk({nm, "_ready_window"}, 32'(ready_ok), 32'd1);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        exp_err;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t tbl[14];
  logic [31:0] mdl_mem [2][16];
  logic [31:0] mdl_dout [2];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 32'h10,  4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h10,  4'h0, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 1'b1, 32'h12,  4'h4, 32'h00AA0000, 1'b0, 32'hDEADBEEF};
    tbl[3]  = '{1'b1, 1'b0, 32'h10,  4'h0, 32'h0,        1'b0, 32'hDEAABEEF};
    tbl[4]  = '{1'b0, 1'b1, 32'h10,  4'h0, 32'hFFFFFFFF, 1'b0, 32'hDEAABEEF};
    tbl[5]  = '{1'b1, 1'b0, 32'h10,  4'h0, 32'h0,        1'b0, 32'hDEAABEEF};
    tbl[6]  = '{1'b0, 1'b1, 32'h0,   4'hF, 32'hCAFEF00D, 1'b0, 32'hDEAABEEF};
    tbl[7]  = '{1'b1, 1'b0, 32'h100, 4'h0, 32'h0,        1'b1, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 32'h100, 4'hF, 32'h99999999, 1'b1, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,   4'h0, 32'h0,        1'b0, 32'hCAFEF00D};
    tbl[10] = '{1'b1, 1'b1, 32'h0,   4'hF, 32'h55555555, 1'b1, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 32'h3,   4'h0, 32'h0,        1'b0, 32'hCAFEF00D};
    tbl[12] = '{1'b0, 1'b1, 32'h20,  4'hF, 32'h11111111, 1'b0, 32'hCAFEF00D};
    tbl[13] = '{1'b1, 1'b0, 32'h20,  4'h0, 32'h0,        1'b0, 32'h11111111};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("reset_ready", 32'(rdy), 32'd1);
      chk("reset_resp", 32'(rsp), 32'd0);
      chk("reset_err", 32'(er), 32'd0);
      chk("reset_dout", dout, 32'd0);
    end

    for (int i = 0; i < 14; i++)
      do_req(1'b1, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].mask, tbl[i].data,
             tbl[i].exp_err, tbl[i].exp_dout, $sformatf("vec%0d", i));

    // Idle noise: valid with no operation must be ignored.
    @(negedge clk);
    sel = 1'b1; rv = 1'b1; rd_d = 1'b0; wr_d = 1'b0; addr_d = 32'h10;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("idle_noise_ready", 32'(rdy), 32'd1);
      chk("idle_noise_resp", 32'(rsp), 32'd0);
    end
    rv = 1'b0;

    // Reset during the wait of a write: write discarded, outputs cleared at once.
    @(negedge clk);
    sel = 1'b1; rv = 1'b1; rd_d = 1'b0; wr_d = 1'b1; addr_d = 32'h20;
    data_d = 32'h12345678; mask_d = 4'hF;
    @(negedge clk);
    rv = 1'b0;
    chk("rst_mid_busy", 32'(rdy), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(rdy), 32'd1);
    chk("rst_mid_resp", 32'(rsp), 32'd0);
    chk("rst_mid_err", 32'(er), 32'd0);
    chk("rst_mid_dout", dout, 32'd0);
    #1 rst_n = 1'b1;
    begin
      int seen = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (rsp) seen++;
      end
      chk("rst_mid_no_resp", 32'(seen), 32'd0);
    end
    do_req(1'b1, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 32'h11111111, "rst_readback");

    // Zero wait states, request held valid: one acceptance every three cycles.
    do_req(1'b0, 1'b0, 1'b1, 32'h0, 4'hF, 32'hA0A0A0A0, 1'b0, 32'h0, "b2b_pre0");
    do_req(1'b0, 1'b0, 1'b1, 32'h4, 4'hF, 32'hB1B1B1B1, 1'b0, 32'h0, "b2b_pre1");
    @(negedge clk);
    sel = 1'b0; rv = 1'b1; rd_d = 1'b1; wr_d = 1'b0; addr_d = 32'h0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("b2b_ready%0d", k), 32'(rdy), 32'((k % 3) == 0));
      chk($sformatf("b2b_resp%0d", k), 32'(rsp), 32'((k % 3) == 2));
      if (k == 2) chk("b2b_dout0", dout, 32'hA0A0A0A0);
      if (k == 5) chk("b2b_dout1", dout, 32'hB1B1B1B1);
      if (k == 1) addr_d = 32'h4;
    end
    rv = 1'b0;

    // Randomized traffic against a byte-level model on both instances.
    for (int s = 0; s < 2; s++) begin
      do_req(1'(s), 1'b1, 1'b0, 32'h4000_0000, 4'h0, 32'h0, 1'b1, 32'h0, "rand_clr");
      mdl_dout[s] = 32'h0;
      for (int w = 0; w < 16; w++) begin
        logic [31:0] v;
        v = $urandom;
        do_req(1'(s), 1'b0, 1'b1, 32'(w * 4), 4'hF, v, 1'b0, mdl_dout[s], "rand_pre");
        mdl_mem[s][w] = v;
      end
      for (int i = 0; i < 60; i++) begin
        int kind, w;
        logic r, wrt, e;
        logic [31:0] a, d;
        logic [3:0] m;
        kind = $urandom_range(0, 9);
        w = $urandom_range(0, 15);
        m = 4'($urandom);
        d = $urandom;
        r = 1'($urandom);
        wrt = ~r;
        a = 32'(w * 4) | 32'($urandom_range(0, 3));
        e = 1'b0;
        if (kind >= 7 && kind <= 8) begin
          a = (32'(DEPTH + $urandom_range(0, 1 << 20)) << 2) | 32'($urandom_range(0, 3));
          e = 1'b1;
        end else if (kind == 9) begin
          r = 1'b1; wrt = 1'b1; e = 1'b1;
        end
        if (e) mdl_dout[s] = 32'h0;
        else if (r) mdl_dout[s] = mdl_mem[s][w];
        else
          for (int b = 0; b < 4; b++)
            if (m[b]) mdl_mem[s][w][8*b +: 8] = d[8*b +: 8];
        do_req(1'(s), r, wrt, a, m, d, e, mdl_dout[s], $sformatf("rand%0d_%0d", s, i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
